timer_array: RTL and testbench
==============================

# timer_array

Parametrised multi-channel timer and the successor to the single-channel `timer`. One instance replaces the per-timer instances on the device side of `bridge`: it provides NCH independent down-counters, each with a prescaler, one-shot or auto-reload mode, and a maskable sticky interrupt. The block is programmed over the existing bridge device port (ADD_I / WE_I / DAT_I / DAT_O). It drives one IRQ_O bit per channel onto the CPU HWInt lines.

## Interface
- NCH, 2: number of channels, 1..15.
- CNT_W, 32: counter/preset width, 8..32; registers zero-extend to 32 bits on read.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- ADD_I  input  8  byte address; bits [1:0] ignored.
- WE_I  input  1  write enable, one write per cycle.
- DAT_I  input  32  write data.
- DAT_O  output  32  read data, combinational from ADD_I and the registers.
- IRQ_O  output  NCH  per-channel interrupt: pend[c] & IM[c].

## Operation
Register map:
- Channel c occupies byte base c*16.
- +0x0 CTRL (R/W): [0] EN, [1] MODE (0 one-shot, 1 auto-reload), [3] IM (interrupt enable), [15:8] PSC. Other bits read 0.
- +0x4 PRESET (R/W, CNT_W bits).
- +0x8 COUNT (read-only).
- +0xC STATUS: [0] PEND. Writing 1 to bit 0 clears it; writing 0 has no effect.
- 0xF0 GLOBAL_PEND (R): bit c = pend[c]. Writing a mask clears every set bit.
- Unmapped addresses, and channel numbers >= NCH, read 0 and ignore writes.

Per-channel FSM (IDLE, LOAD, RUN):
- IDLE: COUNT holds its value. A CTRL write with EN=1 moves to LOAD.
- LOAD: on the next edge, COUNT <= PRESET, prescaler counter psc <= 0, state <= RUN.
- RUN, psc != PSC: psc <= psc+1.
- RUN, psc == PSC (a tick): psc <= 0.
  - If COUNT > 1: COUNT <= COUNT-1.
  - Otherwise (expiry): COUNT <= 0 and pend <= 1. MODE=1 moves to LOAD. MODE=0 clears EN and moves to IDLE.
- A CTRL write with EN=0 in any state moves to IDLE on that edge, and COUNT freezes. pend is unchanged.
- A CTRL write with EN=1 while in LOAD or RUN restarts the channel at LOAD.
- A PRESET write during RUN does not change COUNT; it takes effect at the next LOAD.
- PRESET=0 behaves exactly like PRESET=1.
- Expiry and a same-cycle PEND clear on the same channel: set wins and pend stays 1.
- Channels are fully independent. A GLOBAL_PEND write clears several channels on one edge.

Reset (reset==0 at an edge), applied to all channels:
- CTRL, PRESET, COUNT, psc and pend are cleared; state <= IDLE.
- IRQ_O = 0.
- DAT_O reads 0 for all channel registers.
- Reset mid-count abandons the count with no interrupt.

## Timing
- A write is sampled at edge t, and the register reads back its new value after t.
- Enable at edge t: LOAD executes at edge t+1, so COUNT = PRESET is readable after t+1.
- First expiry lands at edge t+1+N*(PSC+1), where N = max(PRESET,1).
- pend and IRQ_O become visible in the cycle after the expiry edge. There is no further delay.
- Auto-reload: an expiry at edge e is followed by LOAD at e+1. The period is N*(PSC+1)+1 cycles.
- A clear write at edge t drops IRQ_O after t, unless an expiry occurs at the same edge.
- IM is applied combinationally. Clearing IM masks IRQ_O immediately and pend is kept, so setting IM again re-asserts IRQ_O.

## Test plan
- Reset, then read every register -> all 0 and IRQ_O=0. Hold reset=0 mid-RUN -> COUNT=0 and no IRQ.
- Channel 0 one-shot with PRESET=5, PSC=0, IM=1, enabled at edge t -> COUNT reads 5,4,3,2,1,0. IRQ_O[0] rises after edge t+6, EN reads 0, and IRQ_O[0] holds until STATUS is written with 1.
- Channel 1 auto-reload with PRESET=3, PSC=2 -> pend sets every 10 cycles (3*3+1). Clearing PEND on the same edge as an expiry leaves pend=1.
- PRESET=0 one-shot with PSC=0 -> expiry at t+2, the same as PRESET=1. With IM=0, pend=1 while IRQ_O stays 0; setting IM=1 raises IRQ_O the next cycle.
- Both channels running; write PRESET=9 to channel 0 during RUN -> current count unaffected and the next reload uses 9. Writing GLOBAL_PEND=0x3 clears both pends on one edge.
- EN=1 rewrite mid-count -> restart from PRESET. Reading or writing a channel number >= NCH or an unmapped offset -> reads 0 and no state change.

Source files
------------

// File: rtl/timer_array.sv
// rtl/timer_array.sv - multi-channel prescaled down-counter timer with sticky maskable interrupts
module timer_array #(
  parameter int NCH   = 2,
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     ADD_I,
  input  logic           WE_I,
  input  logic [31:0]    DAT_I,
  output logic [31:0]    DAT_O,
  output logic [NCH-1:0] IRQ_O
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  logic [3:0]  chan;
  logic [1:0]  off;
  logic        glb_sel;
  logic        glb_wr;
  logic        unused_ok;

  logic [31:0]    ctrl_rd   [NCH];
  logic [31:0]    preset_rd [NCH];
  logic [31:0]    count_rd  [NCH];
  logic [NCH-1:0] pend_vec;

  assign chan      = ADD_I[7:4];
  assign off       = ADD_I[3:2];
  assign glb_sel   = (ADD_I[7:2] == 6'b111100);
  assign glb_wr    = WE_I && glb_sel;
  assign unused_ok = ^{ADD_I[1:0], DAT_I};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t           state_q, state_d;
    logic             en_q, en_d, mode_q, mode_d, im_q, im_d, pend_q, pend_d;
    logic [7:0]       psc_q, psc_d, pcnt_q, pcnt_d;
    logic [CNT_W-1:0] preset_q, preset_d, count_q, count_d;
    logic             ch_wr, ctrl_wr, preset_wr, clr, expire;

    assign ch_wr     = WE_I && (chan == 4'(c));
    assign ctrl_wr   = ch_wr && (off == 2'd0);
    assign preset_wr = ch_wr && (off == 2'd1);
    assign clr       = (ch_wr && (off == 2'd3) && DAT_I[0]) || (glb_wr && DAT_I[c]);

    always_comb begin
      state_d  = state_q;
      en_d     = en_q;
      mode_d   = mode_q;
      im_d     = im_q;
      psc_d    = psc_q;
      pcnt_d   = pcnt_q;
      preset_d = preset_q;
      count_d  = count_q;
      expire   = 1'b0;
      // A CTRL write overrides the FSM for this edge; count and prescaler hold.
      if (ctrl_wr) begin
        en_d    = DAT_I[0];
        mode_d  = DAT_I[1];
        im_d    = DAT_I[3];
        psc_d   = DAT_I[15:8];
        state_d = DAT_I[0] ? LOAD : IDLE;
      end else begin
        case (state_q)
          LOAD: begin
            count_d = preset_q;
            pcnt_d  = 8'd0;
            state_d = RUN;
          end
          RUN: begin
            if (pcnt_q != psc_q) begin
              pcnt_d = pcnt_q + 8'd1;
            end else begin
              pcnt_d = 8'd0;
              if (count_q > CNT_W'(1)) begin
                count_d = count_q - CNT_W'(1);
              end else begin
                expire  = 1'b1;
                count_d = '0;
                if (mode_q) begin
                  state_d = LOAD;
                end else begin
                  en_d    = 1'b0;
                  state_d = IDLE;
                end
              end
            end
          end
          default: ;
        endcase
      end
      if (preset_wr) preset_d = DAT_I[CNT_W-1:0];
    end

    // Expiry wins over a same-edge clear.
    assign pend_d = expire ? 1'b1 : (clr ? 1'b0 : pend_q);

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q  <= IDLE;
        en_q     <= 1'b0;
        mode_q   <= 1'b0;
        im_q     <= 1'b0;
        psc_q    <= 8'd0;
        pcnt_q   <= 8'd0;
        preset_q <= '0;
        count_q  <= '0;
        pend_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        en_q     <= en_d;
        mode_q   <= mode_d;
        im_q     <= im_d;
        psc_q    <= psc_d;
        pcnt_q   <= pcnt_d;
        preset_q <= preset_d;
        count_q  <= count_d;
        pend_q   <= pend_d;
      end
    end

    assign ctrl_rd[c]   = {16'd0, psc_q, 4'd0, im_q, 1'b0, mode_q, en_q};
    assign preset_rd[c] = 32'(preset_q);
    assign count_rd[c]  = 32'(count_q);
    assign pend_vec[c]  = pend_q;
    assign IRQ_O[c]     = pend_q & im_q;
  end

  always_comb begin
    DAT_O = 32'd0;
    if (glb_sel) begin
      DAT_O = 32'(pend_vec);
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (chan == 4'(c)) begin
          case (off)
            2'd0:    DAT_O = ctrl_rd[c];
            2'd1:    DAT_O = preset_rd[c];
            2'd2:    DAT_O = count_rd[c];
            default: DAT_O = {31'd0, pend_vec[c]};
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_array.sv
// tb/tb_timer_array.sv - directed self-checking bench for timer_array
module tb_timer_array;

  logic        clk;
  logic        reset;
  logic [7:0]  ADD_I;
  logic        WE_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic [1:0]  IRQ_O;

  int checks = 0;
  int errors = 0;

  timer_array #(.NCH(2), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .ADD_I (ADD_I),
    .WE_I  (WE_I),
    .DAT_I (DAT_I),
    .DAT_O (DAT_O),
    .IRQ_O (IRQ_O)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    ADD_I = a;
    DAT_I = d;
    WE_I  = 1'b1;
    @(posedge clk);
    #1;
    WE_I  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    ADD_I = a;
    #1;
    check(tag, DAT_O, exp);
  endtask

  initial begin
    logic [7:0] regs [9];
    regs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'hF0};
    reset = 1'b0;
    ADD_I = 8'h00;
    WE_I  = 1'b0;
    DAT_I = 32'd0;
    step(3);
    reset = 1'b1;
    step(1);

    // reset state
    for (int i = 0; i < 9; i++) rd_chk($sformatf("rst_reg%0h", regs[i]), regs[i], 32'd0);
    check("rst_irq", 32'(IRQ_O), 32'd0);

    // ch0 one-shot PRESET=5 PSC=0 IM=1
    wr(8'h04, 32'd5);
    wr(8'h00, 32'h9);
    step(1);
    rd_chk("os_cnt5", 8'h08, 32'd5);
    for (int k = 4; k >= 1; k--) begin
      step(1);
      rd_chk($sformatf("os_cnt%0d", k), 8'h08, 32'(k));
    end
    check("os_irq_early", 32'(IRQ_O[0]), 32'd0);
    step(1);
    rd_chk("os_cnt0", 8'h08, 32'd0);
    check("os_irq_set", 32'(IRQ_O[0]), 32'd1);
    rd_chk("os_en_clr", 8'h00, 32'h8);
    step(3);
    wr(8'h0C, 32'd0);
    check("os_irq_hold", 32'(IRQ_O[0]), 32'd1);
    wr(8'h0C, 32'd1);
    check("os_irq_clr", 32'(IRQ_O[0]), 32'd0);
    rd_chk("os_pend_clr", 8'h0C, 32'd0);

    // ch1 auto-reload PRESET=3 PSC=2, period 10
    wr(8'h14, 32'd3);
    wr(8'h10, 32'h20B);
    rd_chk("ar_ctrl", 8'h10, 32'h20B);
    step(9);
    rd_chk("ar_pend_pre", 8'h1C, 32'd0);
    step(1);
    rd_chk("ar_pend_1", 8'h1C, 32'd1);
    check("ar_irq", 32'(IRQ_O[1]), 32'd1);
    wr(8'h1C, 32'd1);
    rd_chk("ar_pend_clr", 8'h1C, 32'd0);
    step(8);
    rd_chk("ar_cnt_pre2", 8'h18, 32'd1);
    rd_chk("ar_pend_pre2", 8'h1C, 32'd0);
    wr(8'h1C, 32'd1);
    rd_chk("ar_set_wins", 8'h1C, 32'd1);
    wr(8'h1C, 32'd1);
    wr(8'h10, 32'd0);
    rd_chk("ar_pend_clr2", 8'h1C, 32'd0);

    // PRESET=0 behaves as 1; IM masking
    wr(8'h04, 32'd0);
    wr(8'h00, 32'h1);
    step(1);
    rd_chk("p0_pend_t1", 8'h0C, 32'd0);
    step(1);
    rd_chk("p0_pend_t2", 8'h0C, 32'd1);
    check("p0_irq_masked", 32'(IRQ_O[0]), 32'd0);
    wr(8'h00, 32'h8);
    check("p0_irq_unmask", 32'(IRQ_O[0]), 32'd1);
    wr(8'h00, 32'h0);
    check("p0_irq_remask", 32'(IRQ_O[0]), 32'd0);
    rd_chk("p0_pend_kept", 8'h0C, 32'd1);
    wr(8'h0C, 32'd1);

    // both channels; PRESET write during RUN; global clear
    wr(8'h04, 32'd20);
    wr(8'h00, 32'h3);
    step(3);
    rd_chk("pr_cnt18", 8'h08, 32'd18);
    wr(8'h04, 32'd9);
    rd_chk("pr_cnt17", 8'h08, 32'd17);
    rd_chk("pr_preset9", 8'h04, 32'd9);
    wr(8'h14, 32'd2);
    wr(8'h10, 32'h1);
    step(14);
    rd_chk("pr_cnt1", 8'h08, 32'd1);
    step(1);
    rd_chk("pr_exp_pend", 8'h0C, 32'd1);
    step(1);
    rd_chk("pr_reload9", 8'h08, 32'd9);
    rd_chk("gp_both", 8'hF0, 32'h3);
    rd_chk("ch1_en_clr", 8'h10, 32'h0);
    wr(8'hF0, 32'h3);
    rd_chk("gp_clr", 8'hF0, 32'h0);
    wr(8'h00, 32'h0);

    // EN rewrite restarts; EN=0 freezes count
    wr(8'h00, 32'h1);
    step(3);
    rd_chk("rs_cnt7", 8'h08, 32'd7);
    wr(8'h00, 32'h1);
    step(1);
    rd_chk("rs_cnt9", 8'h08, 32'd9);
    wr(8'h00, 32'h0);
    step(2);
    rd_chk("rs_frozen", 8'h08, 32'd9);

    // out-of-range channel and unmapped offsets
    wr(8'h20, 32'hFFFF_FFFF);
    wr(8'h24, 32'hFFFF_FFFF);
    wr(8'hF4, 32'hFFFF_FFFF);
    rd_chk("um_ch2", 8'h20, 32'd0);
    rd_chk("um_ch2p", 8'h24, 32'd0);
    rd_chk("um_f4", 8'hF4, 32'd0);
    rd_chk("um_ch0_preset", 8'h05, 32'd9);
    rd_chk("um_ch0_ctrl", 8'h00, 32'd0);
    check("um_irq", 32'(IRQ_O), 32'd0);

    // reset mid-RUN abandons the count
    wr(8'h00, 32'h9);
    step(3);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(12);
    rd_chk("mr_cnt", 8'h08, 32'd0);
    rd_chk("mr_ctrl", 8'h00, 32'd0);
    rd_chk("mr_preset", 8'h04, 32'd0);
    rd_chk("mr_pend", 8'hF0, 32'd0);
    check("mr_irq", 32'(IRQ_O), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
